// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes minimal control, bypasses WB writes, inserts load-use bubbles.
// Latency 1 cycle; ex_hold freezes the register, flush kills it, and id_stall holds upstream.
module id_ex_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [31:0]            id_pc,
    input  logic [31:0]            id_instr,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    input  logic                   wb_regwrite,
    input  logic [4:0]             wb_dest,
    input  logic [31:0]            wb_data,
    input  logic                   ex_hold,
    input  logic                   flush,
    output logic                   id_stall,
    output logic                   ex_valid,
    output logic [31:0]            ex_pc,
    output logic [31:0]            ex_rs_val,
    output logic [31:0]            ex_rt_val,
    output logic [31:0]            ex_imm,
    output logic [4:0]             ex_rs,
    output logic [4:0]             ex_rt,
    output logic [4:0]             ex_dest,
    output logic [5:0]             ex_opcode,
    output logic [5:0]             ex_funct,
    output logic [4:0]             ex_shamt,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic [STALL_CNT_W-1:0] bubble_count
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        uses_rt;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hazard;

    assign opcode = id_instr[31:26];
    assign rs_f   = id_instr[25:21];
    assign rt_f   = id_instr[20:16];
    assign rd_f   = id_instr[15:11];
    assign funct  = id_instr[5:0];

    always_comb begin
        dest      = 5'd0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        uses_rt   = 1'b0;
        if (opcode >= 6'h0C && opcode <= 6'h0E)
            imm = {16'h0000, id_instr[15:0]};
        else
            imm = {{16{id_instr[15]}}, id_instr[15:0]};

        if (opcode == 6'h00) begin
            dest      = rd_f;
            reg_write = (funct != 6'h08);
            uses_rt   = 1'b1;
        end else if (opcode >= 6'h08 && opcode <= 6'h0F) begin
            dest      = rt_f;
            reg_write = 1'b1;
        end else if (opcode == 6'h23) begin
            dest      = rt_f;
            reg_write = 1'b1;
            mem_read  = 1'b1;
        end else if (opcode == 6'h2B) begin
            mem_write = 1'b1;
            uses_rt   = 1'b1;
        end else if (opcode == 6'h04 || opcode == 6'h05) begin
            uses_rt   = 1'b1;
        end else if (opcode == 6'h03) begin
            dest      = 5'd31;
            reg_write = 1'b1;
        end

        // Writes to $zero are architecturally discarded; never advertise them.
        if (dest == 5'd0)
            reg_write = 1'b0;
    end

    assign rs_val = (wb_regwrite && wb_dest != 5'd0 && wb_dest == rs_f) ? wb_data : rs_data;
    assign rt_val = (wb_regwrite && wb_dest != 5'd0 && wb_dest == rt_f) ? wb_data : rt_data;

    assign hazard = ex_valid && ex_mem_read && (ex_dest != 5'd0) && id_valid &&
                    ((ex_dest == rs_f) || (uses_rt && ex_dest == rt_f));

    // Gated by rst_n so an asserted ex_hold cannot leak a stall out of reset.
    assign id_stall = rst_n && !flush && (ex_hold || hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs_val    <= '0;
            ex_rt_val    <= '0;
            ex_imm       <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dest      <= '0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_shamt     <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            bubble_count <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (ex_hold) begin
            ex_valid     <= ex_valid;
        end else if (hazard) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            if (bubble_count != '1)
                bubble_count <= bubble_count + 1'b1;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs_val    <= rs_val;
            ex_rt_val    <= rt_val;
            ex_imm       <= imm;
            ex_rs        <= rs_f;
            ex_rt        <= rt_f;
            ex_dest      <= dest;
            ex_opcode    <= opcode;
            ex_funct     <= funct;
            ex_shamt     <= id_instr[10:6];
            ex_reg_write <= reg_write && id_valid;
            ex_mem_read  <= mem_read && id_valid;
            ex_mem_write <= mem_write && id_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        ex_hold;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_shamt;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [W-1:0] bubble_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI = 32'h2128FFFC;  // addi $t0,$t1,-4
    localparam logic [31:0] LW   = 32'h8E080000;  // lw  $t0,0($s0)
    localparam logic [31:0] ADD  = 32'h01095020;  // add $t2,$t0,$t1
    localparam logic [31:0] SW   = 32'hAE280000;  // sw  $t0,0($s1)
    localparam logic [31:0] ORI  = 32'h34088000;  // ori $t0,$zero,0x8000
    localparam logic [31:0] JR   = 32'h03E00008;  // jr  $ra
    localparam logic [31:0] JAL  = 32'h0C000000;  // jal 0

    always #5 clk = ~clk;

    id_ex_stage #(.STALL_CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .bubble_count(bubble_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] rs, input logic [31:0] rt);
        id_valid = v;
        id_pc    = pc;
        id_instr = instr;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a load then a dependent instruction; expects exactly one bubble.
    task automatic load_use(input logic [31:0] dep, input logic [31:0] exp_cnt, input string tag);
        drive(1'b1, 32'h100, LW, 32'd0, 32'd0);
        step();
        drive(1'b1, 32'h104, dep, 32'd1, 32'd2);
        #1;
        check({tag, "_stall_on"}, 32'(id_stall), 32'd1);
        step();
        check({tag, "_bubble_vld"}, 32'(ex_valid), 32'd0);
        check({tag, "_cnt"}, 32'(bubble_count), exp_cnt);
        check({tag, "_stall_off"}, 32'(id_stall), 32'd0);
        step();
        check({tag, "_issue_vld"}, 32'(ex_valid), 32'd1);
        check({tag, "_issue_pc"}, ex_pc, 32'h104);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        wb_regwrite = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
        ex_hold = 1'b0; flush = 1'b0;
        #12;
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_cnt", 32'(bubble_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Pass-through of addi with sign-extended immediate
        drive(1'b1, 32'h40, ADDI, 32'd10, 32'd0);
        step();
        check("addi_vld", 32'(ex_valid), 32'd1);
        check("addi_dest", 32'(ex_dest), 32'd8);
        check("addi_imm", ex_imm, 32'hFFFFFFFC);
        check("addi_rw", 32'(ex_reg_write), 32'd1);
        check("addi_rsval", ex_rs_val, 32'd10);

        // ori zero-extends
        drive(1'b1, 32'h44, ORI, 32'd0, 32'd0);
        step();
        check("ori_imm", ex_imm, 32'h00008000);
        check("ori_dest", 32'(ex_dest), 32'd8);

        drive(1'b1, 32'h48, JR, 32'd0, 32'd0);
        step();
        check("jr_rw", 32'(ex_reg_write), 32'd0);
        drive(1'b1, 32'h4C, JAL, 32'd0, 32'd0);
        step();
        check("jal_dest", 32'(ex_dest), 32'd31);
        check("jal_rw", 32'(ex_reg_write), 32'd1);

        // Invalid slot loads control as zero
        drive(1'b0, 32'h50, ADDI, 32'd0, 32'd0);
        step();
        check("inv_vld", 32'(ex_valid), 32'd0);
        check("inv_rw", 32'(ex_reg_write), 32'd0);

        // WB bypass into rs (rs field = 9)
        wb_regwrite = 1'b1; wb_dest = 5'd9; wb_data = 32'hDEADBEEF;
        drive(1'b1, 32'h54, ADDI, 32'd0, 32'd0);
        step();
        check("byp_rs", ex_rs_val, 32'hDEADBEEF);
        wb_dest = 5'd0;
        step();
        check("byp_zero", ex_rs_val, 32'd0);
        wb_regwrite = 1'b0;

        load_use(ADD, 32'd1, "lu_add");
        check("lu_add_dest", 32'(ex_dest), 32'd10);
        load_use(SW, 32'd2, "lu_sw");
        check("lu_sw_mw", 32'(ex_mem_write), 32'd1);

        // Flush during a hazard: no stall, no count
        drive(1'b1, 32'h100, LW, 32'd0, 32'd0);
        step();
        check("lu_ld_mr", 32'(ex_mem_read), 32'd1);
        drive(1'b1, 32'h104, ADD, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        check("fh_stall", 32'(id_stall), 32'd0);
        step();
        flush = 1'b0;
        check("fh_vld", 32'(ex_valid), 32'd0);
        check("fh_cnt", 32'(bubble_count), 32'd2);

        // Saturation at 2'b11
        load_use(ADD, 32'd3, "sat1");
        load_use(ADD, 32'd3, "sat2");
        load_use(SW, 32'd3, "sat3");

        // Hold for 3 cycles, then flush+hold
        drive(1'b1, 32'h200, ADDI, 32'd7, 32'd0);
        step();
        ex_hold = 1'b1;
        drive(1'b1, 32'h204, ORI, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_stall", 32'(id_stall), 32'd1);
            step();
            check("hold_pc", ex_pc, 32'h200);
            check("hold_vld", 32'(ex_valid), 32'd1);
        end
        flush = 1'b1;
        #1;
        check("fl_stall", 32'(id_stall), 32'd0);
        step();
        check("fl_vld", 32'(ex_valid), 32'd0);
        check("fl_rw", 32'(ex_reg_write), 32'd0);
        flush = 1'b0;
        ex_hold = 1'b0;

        // Asynchronous reset mid-cycle with a valid slot and ex_hold asserted
        drive(1'b1, 32'h300, ADDI, 32'd5, 32'd0);
        step();
        check("pre_rst_vld", 32'(ex_valid), 32'd1);
        ex_hold = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(ex_valid), 32'd0);
        check("arst_pc", ex_pc, 32'd0);
        check("arst_rsval", ex_rs_val, 32'd0);
        check("arst_imm", ex_imm, 32'd0);
        check("arst_rw", 32'(ex_reg_write), 32'd0);
        check("arst_cnt", 32'(bubble_count), 32'd0);
        check("arst_stall", 32'(id_stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode/register-read stage and the execute stage of the 5-stage MIPS core.
- Captures the decoder's operand outputs (out1/out2) with the PC and instruction, and derives minimal control: dest register, reg_write, mem_read, immediate.
- Detects load-use hazards, inserts bubbles and stalls upstream. Honours downstream stall and branch flush.
- Bypasses a same-cycle write-back into captured operands.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_pc  in  32  PC of decode instruction.
- id_instr  in  32  instruction word.
- rs_data  in  32  register-file read data for instr[25:21] (decoder out1).
- rt_data  in  32  register-file read data for instr[20:16] (decoder out2).
- wb_regwrite  in  1  write-back stage writing this cycle.
- wb_dest  in  5  write-back destination.
- wb_data  in  32  write-back value.
- ex_hold  in  1  execute stage cannot accept (multicycle op).
- flush  in  1  kill decode and execute contents (taken branch/jump).
- id_stall  out  1  upstream (IF/ID) must hold.
- ex_valid  out  1  execute-stage slot valid.
- ex_pc, ex_rs_val, ex_rt_val, ex_imm  out  32 each  registered PC, operands, extended immediate.
- ex_rs, ex_rt, ex_dest  out  5 each  source and destination register numbers.
- ex_opcode, ex_funct  out  6 each; ex_shamt  out  5.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each.
- bubble_count  out  STALL_CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset (async, rst_n=0): every output register 0, bubble_count 0. id_stall is combinational and reads 0 while in reset.
- Decode (combinational on id_instr):
  - opcode 0x00 (R-type): dest=rd, reg_write=1 except funct 0x08 (jr), uses_rt=1.
  - 0x08–0x0F (I-ALU): dest=rt, reg_write=1, uses_rt=0. Imm is zero-extended for 0x0C–0x0E, sign-extended otherwise.
  - 0x23 (lw): dest=rt, reg_write=1, mem_read=1.
  - 0x2B (sw): mem_write=1, uses_rt=1.
  - 0x04/0x05 (beq/bne): uses_rt=1, no write.
  - 0x03 (jal): dest=31, reg_write=1.
  - 0x02 (j) and all other opcodes: no write, no mem.
  - Any dest of 0 forces reg_write=0.
- Hazard condition: ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==instr[25:21] | (uses_rt & ex_dest==instr[20:16])).
- WB bypass: if wb_regwrite & wb_dest!=0 & wb_dest==rs field, capture wb_data instead of rs_data. Same rule independently for rt.
- Per-edge priority:
  1. flush: ex_valid<=0 and all control outputs <=0; data fields don't-care.
  2. ex_hold: all registers hold.
  3. hazard: bubble (ex_valid<=0, ex_reg_write/mem_read/mem_write<=0); bubble_count += 1, saturating at all-ones.
  4. otherwise: load decode fields; ex_valid<=id_valid. When id_valid=0, control bits are loaded as 0.
- id_stall = ~flush & (ex_hold | hazard). Combinational; no latency.
- Latency: one cycle from decode to ex_* outputs. A load followed immediately by a dependent instruction sees exactly one bubble; the dependency is then resolved by downstream forwarding.
- Flush during hazard or hold: flush wins; id_stall=0 and the counter does not increment.
- Reset mid-stall clears everything immediately, without waiting for a clock edge.

Test Plan:
- Reset: rst_n=0 mid-cycle with ex_valid=1 -> all ex_* outputs and bubble_count read 0 before the next edge; id_stall=0.
- Pass-through: addi $t0,$t1,-4 (0x2128FFFC), rs_data=10 -> next cycle ex_valid=1, ex_dest=8, ex_imm=0xFFFFFFFC, ex_reg_write=1, ex_rs_val=10.
- Load-use: lw $t0,0($s0) then add $t2,$t0,$t1 -> one bubble; id_stall=1 for exactly one cycle; bubble_count=1; add issues on the following cycle. Repeat with sw $t0 using rt -> same single-bubble result.
- WB bypass: wb_regwrite=1, wb_dest=9, wb_data=0xDEADBEEF, rs field=9, rs_data=0 -> ex_rs_val=0xDEADBEEF. Repeat with wb_dest=0 -> ex_rs_val=0.
- Hold vs flush: ex_hold=1 for 3 cycles -> outputs stable and id_stall=1. Then flush and ex_hold together -> ex_valid=0 next edge and id_stall=0.
- Saturation with STALL_CNT_W=2: 5 consecutive load-use pairs -> bubble_count stops at 3. ori immediate 0x8000 -> ex_imm=0x00008000.
